// File: rtl/mining_result_logger.sv
// mining_result_logger: times each armed mining job and queues its result for word-wise host readout.
module mining_result_logger #(
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             job_start,
  input  logic             process_done,
  input  logic             success,
  input  logic [255:0]     hash_in,
  input  logic [31:0]      nonce_in,
  input  logic [3:0]       rd_word_sel,
  input  logic             rd_pop,
  input  logic             clr_overflow,
  output logic [31:0]      rd_data,
  output logic             not_empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);
  localparam int PW = $clog2(DEPTH);
  typedef struct packed {
    logic [255:0] hash;
    logic [31:0]  nonce;
    logic         success;
    logic [31:0]  cycles;
  } entry_t;
  logic             start_q, done_q;
  logic             armed_q, armed_d;
  logic [31:0]      cycles_q, cycles_d, cycles_inc;
  logic [PW-1:0]    wr_q, rd_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             start_rise, capture, empty, full, pop_ok, push_ok;
  entry_t           mem_q [DEPTH];
  entry_t           head, new_entry;
  always_comb begin
    start_rise = job_start & ~start_q;
    capture    = process_done & ~done_q & armed_q;
    cycles_inc = &cycles_q ? cycles_q : cycles_q + 32'd1;
    // a job_start rise in the capture cycle wins, so the next job restarts at zero
    armed_d    = start_rise | (armed_q & ~capture);
    cycles_d   = start_rise ? '0 : armed_q ? cycles_inc : cycles_q;
    empty      = count_q == '0;
    full       = count_q == CNT_W'(DEPTH);
    pop_ok     = rd_pop & ~empty;
    push_ok    = capture & (~full | pop_ok);
    count_d    = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    overflow_d = (capture & ~push_ok) | (overflow_q & ~clr_overflow);
    new_entry  = '{hash: hash_in, nonce: nonce_in, success: success, cycles: cycles_inc};
    head       = mem_q[rd_q];
    rd_data_d  = rd_word_sel == 4'd11 ? {overflow_q, {(31-CNT_W){1'b0}}, count_q} :
                 (empty || rd_word_sel > 4'd10) ? 32'd0 :
                 !rd_word_sel[3] ? head.hash[{rd_word_sel[2:0], 5'b0} +: 32] :
                 rd_word_sel[1] ? {31'd0, head.success} :
                 rd_word_sel[0] ? head.cycles : head.nonce;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      armed_q    <= 1'b0;
      cycles_q   <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      start_q    <= job_start;
      done_q     <= process_done;
      armed_q    <= armed_d;
      cycles_q   <= cycles_d;
      wr_q       <= push_ok ? wr_q + PW'(1) : wr_q;
      rd_q       <= pop_ok ? rd_q + PW'(1) : rd_q;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rd_data_q  <= rd_data_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem_q[wr_q] <= new_entry;
  end
  assign rd_data   = rd_data_q;
  assign not_empty = count_q != '0;
  assign count     = count_q;
  assign overflow  = overflow_q;
endmodule
